uart_mult_byte_tx: RTL and testbench

UART_MULT_BYTE_TX -- requirements
Module: uart_mult_byte_tx

---
 rtl/uart_mult_byte_tx.sv | 121 ++++++++++++
 tb/tb_uart_mult_byte_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mult_byte_tx.sv
// Serialises a fixed 8-byte frame (0x55, A, B lo/hi, C lo/hi, CR, LF) as back-to-back
// 8N1 UART characters. The payload is captured when the frame is accepted.
module uart_mult_byte_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_en,
  input  logic [7:0]  dataA,
  input  logic [15:0] dataB,
  input  logic [15:0] dataC,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic [2:0]  byte_idx,
  output logic        byte_done,
  output logic        pack_done
);

  localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  data_a_q, data_a_d;
  logic [15:0] data_b_q, data_b_d;
  logic [15:0] data_c_q, data_c_d;
  logic        bit_end;
  logic        accept;
  logic [7:0]  cur_byte;

  assign bit_end = (clk_cnt_q == BIT_LAST);
  assign accept  = (state_q == IDLE) && send_en;

  // State register; sys_rst_n is an active-high synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (send_en) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_cnt_q == 3'd7) state_d = STOP;
      STOP:  if (bit_end) state_d = (byte_idx_q == 3'd7) ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Bit-period, bit and byte counters plus the captured payload
  always_comb begin
    clk_cnt_d  = (state_q == IDLE || bit_end) ? 16'd0 : clk_cnt_q + 16'd1;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    data_c_d   = data_c_q;
    if (state_q != DATA)  bit_cnt_d = 3'd0;
    else if (bit_end)     bit_cnt_d = bit_cnt_q + 3'd1;
    if (state_q == IDLE)  byte_idx_d = 3'd0;
    else if (state_q == STOP && bit_end)
      byte_idx_d = (byte_idx_q == 3'd7) ? 3'd0 : byte_idx_q + 3'd1;
    if (accept) begin
      data_a_d = dataA;
      data_b_d = dataB;
      data_c_d = dataC;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      clk_cnt_q  <= 16'd0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      data_a_q   <= 8'd0;
      data_b_q   <= 16'd0;
      data_c_q   <= 16'd0;
    end else begin
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      data_c_q   <= data_c_d;
    end
  end

  always_comb begin
    unique case (byte_idx_q)
      3'd0:    cur_byte = 8'h55;
      3'd1:    cur_byte = data_a_q;
      3'd2:    cur_byte = data_b_q[7:0];
      3'd3:    cur_byte = data_b_q[15:8];
      3'd4:    cur_byte = data_c_q[7:0];
      3'd5:    cur_byte = data_c_q[15:8];
      3'd6:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Outputs decode straight from registered state, so they follow reset on the same edge
  always_comb begin
    uart_txd  = 1'b1;
    tx_busy   = (state_q != IDLE);
    byte_idx  = byte_idx_q;
    byte_done = (state_q == STOP) && bit_end;
    pack_done = (state_q == STOP) && bit_end && (byte_idx_q == 3'd7);
    unique case (state_q)
      START:   uart_txd = 1'b0;
      DATA:    uart_txd = cur_byte[bit_cnt_q];
      default: uart_txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Directed bench for uart_mult_byte_tx: a mid-bit sampling receiver decodes the line,
// pulse counters track byte_done/pack_done, and each scenario checks inline.
module tb_uart_mult_byte_tx;
  localparam int CLK_FREQ = 1050;
  localparam int UART_BPS = 100;
  localparam int BPS      = 10;       // 1050/100 truncated
  localparam int FRAME    = 80 * BPS;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        send_en = 1'b0;
  logic [7:0]  dataA = 8'h00;
  logic [15:0] dataB = 16'h0000;
  logic [15:0] dataC = 16'h0000;
  logic        uart_txd, tx_busy, byte_done, pack_done;
  logic [2:0]  byte_idx;

  int checks = 0;
  int failures = 0;
  int bd_cnt = 0;
  int pd_cnt = 0;
  logic [8:0] rx_q[$];   // {stop bit, data byte}

  always #5 sys_clk = ~sys_clk;

  uart_mult_byte_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .send_en(send_en),
    .dataA(dataA), .dataB(dataB), .dataC(dataC),
    .uart_txd(uart_txd), .tx_busy(tx_busy), .byte_idx(byte_idx),
    .byte_done(byte_done), .pack_done(pack_done)
  );

  always @(negedge sys_clk) begin
    if (byte_done === 1'b1) bd_cnt++;
    if (pack_done === 1'b1) pd_cnt++;
  end

  initial begin : rx_mon
    logic [7:0] sh;
    logic       stp;
    forever begin
      @(negedge sys_clk);
      if (uart_txd === 1'b0) begin
        repeat (BPS/2) @(negedge sys_clk);
        if (uart_txd === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BPS) @(negedge sys_clk);
            sh[i] = uart_txd;
          end
          repeat (BPS) @(negedge sys_clk);
          stp = uart_txd;
          rx_q.push_back({stp, sh});
        end
      end
    end
  end

  task automatic clear_obs();
    rx_q.delete();
    bd_cnt = 0;
    pd_cnt = 0;
  endtask

  task automatic start_frame(input logic [7:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge sys_clk);
    send_en = 1'b1; dataA = a; dataB = b; dataC = c;
    @(negedge sys_clk);
    send_en = 1'b0;
  endtask

  // n = frame cycle (1 = first start-bit cycle) on which pack_done is seen
  task automatic wait_pack(output int n);
    n = 1;
    while (pack_done !== 1'b1 && n < 4*FRAME) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    sys_rst_n = 1'b1; send_en = 1'b1; dataA = 8'hFF;
    repeat (3) @(negedge sys_clk);
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL rst_txd got=%b exp=1", uart_txd); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", tx_busy); end
    checks++; if (byte_idx !== 3'd0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", byte_idx); end
    checks++; if (byte_done !== 1'b0 || pack_done !== 1'b0) begin
      failures++; $display("FAIL rst_pulses got=%b%b exp=00", byte_done, pack_done); end
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    send_en = 1'b0;
    checks++; if (tx_busy !== 1'b1 || uart_txd !== 1'b0) begin
      failures++; $display("FAIL first_cycle_accept got busy=%b txd=%b exp busy=1 txd=0", tx_busy, uart_txd); end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    e = {5'd0, byte_idx};
    checks++; if (tx_busy !== 1'b0 || uart_txd !== 1'b1 || e !== 8'd0) begin
      failures++; $display("FAIL rst_abort_early got busy=%b txd=%b idx=%0d exp 0/1/0", tx_busy, uart_txd, e); end
    repeat (2*BPS) @(negedge sys_clk);
    clear_obs();
  endtask

  task automatic test_frame();
    logic [7:0] exp [8] = '{8'h55, 8'h12, 8'h56, 8'h34, 8'h9A, 8'h78, 8'h0D, 8'h0A};
    int n;
    clear_obs();
    start_frame(8'h12, 16'h3456, 16'h789A);
    checks++; if (uart_txd !== 1'b0 || tx_busy !== 1'b1 || byte_idx !== 3'd0) begin
      failures++; $display("FAIL frame_start got txd=%b busy=%b idx=%0d exp 0/1/0", uart_txd, tx_busy, byte_idx); end
    wait_pack(n);
    checks++; if (n !== FRAME) begin failures++; $display("FAIL frame_len got=%0d exp=%0d", n, FRAME); end
    checks++; if (byte_idx !== 3'd7) begin failures++; $display("FAIL pack_idx got=%0d exp=7", byte_idx); end
    @(negedge sys_clk);
    checks++; if (tx_busy !== 1'b0 || uart_txd !== 1'b1 || byte_idx !== 3'd0 || pack_done !== 1'b0) begin
      failures++; $display("FAIL frame_end got busy=%b txd=%b idx=%0d pd=%b exp 0/1/0/0", tx_busy, uart_txd, byte_idx, pack_done); end
    checks++; if (bd_cnt !== 8 || pd_cnt !== 1) begin
      failures++; $display("FAIL frame_pulses got bd=%0d pd=%0d exp 8/1", bd_cnt, pd_cnt); end
    checks++; if (rx_q.size() !== 8) begin failures++; $display("FAIL frame_nbytes got=%0d exp=8", rx_q.size()); end
    for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== {1'b1, exp[k]}) begin
        failures++; $display("FAIL frame_byte%0d got=%h exp=%h", k, rx_q[k], {1'b1, exp[k]}); end
    end
    if (rx_q.size() >= 6) begin
      checks++; if ({rx_q[3][7:0], rx_q[2][7:0]} !== 16'h3456 || {rx_q[5][7:0], rx_q[4][7:0]} !== 16'h789A) begin
        failures++; $display("FAIL rx_fields got B=%h C=%h exp 3456/789a",
          {rx_q[3][7:0], rx_q[2][7:0]}, {rx_q[5][7:0], rx_q[4][7:0]}); end
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] exp [8] = '{8'h55, 8'h11, 8'h33, 8'h22, 8'h55, 8'h44, 8'h0D, 8'h0A};
    int  n;
    bit  pulsed;
    clear_obs();
    pulsed = 1'b0;
    start_frame(8'h11, 16'h2233, 16'h4455);
    n = 1;
    while (pack_done !== 1'b1 && n < 4*FRAME) begin
      if (byte_idx == 3'd3 && !pulsed) begin
        send_en = 1'b1; dataA = 8'hEE; dataB = 16'hDDCC; dataC = 16'hBBAA; pulsed = 1'b1;
      end else send_en = 1'b0;
      @(negedge sys_clk);
      n++;
    end
    send_en = 1'b0;
    checks++; if (n !== FRAME) begin failures++; $display("FAIL busy_len got=%0d exp=%0d", n, FRAME); end
    repeat (20*BPS) @(negedge sys_clk);
    checks++; if (pd_cnt !== 1 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL busy_queued got pd=%0d busy=%b exp 1/0", pd_cnt, tx_busy); end
    checks++; if (rx_q.size() !== 8) begin failures++; $display("FAIL busy_nbytes got=%0d exp=8", rx_q.size()); end
    for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== {1'b1, exp[k]}) begin
        failures++; $display("FAIL busy_byte%0d got=%h exp=%h", k, rx_q[k], {1'b1, exp[k]}); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp [8] = '{8'h55, 8'hA5, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h0D, 8'h0A};
    int n;
    clear_obs();
    start_frame(8'hA5, 16'h00FF, 16'h8001);
    n = 0;
    while (byte_idx !== 3'd4 && n < 4*FRAME) begin @(negedge sys_clk); n++; end
    repeat (3*BPS) @(negedge sys_clk);
    checks++; if (tx_busy !== 1'b1 || byte_idx !== 3'd4) begin
      failures++; $display("FAIL abort_pre got busy=%b idx=%0d exp 1/4", tx_busy, byte_idx); end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    checks++; if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || byte_idx !== 3'd0) begin
      failures++; $display("FAIL abort_next got txd=%b busy=%b idx=%0d exp 1/0/0", uart_txd, tx_busy, byte_idx); end
    repeat (20*BPS) @(negedge sys_clk);
    checks++; if (pd_cnt !== 0 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL abort_pack got pd=%0d busy=%b exp 0/0", pd_cnt, tx_busy); end
    clear_obs();
    start_frame(8'hA5, 16'h00FF, 16'h8001);
    wait_pack(n);
    checks++; if (n !== FRAME) begin failures++; $display("FAIL abort_relen got=%0d exp=%0d", n, FRAME); end
    @(negedge sys_clk);
    checks++; if (rx_q.size() !== 8) begin failures++; $display("FAIL abort_nbytes got=%0d exp=8", rx_q.size()); end
    for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== {1'b1, exp[k]}) begin
        failures++; $display("FAIL abort_byte%0d got=%h exp=%h", k, rx_q[k], {1'b1, exp[k]}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [16] = '{8'h55, 8'h01, 8'h03, 8'h02, 8'h05, 8'h04, 8'h0D, 8'h0A,
                             8'h55, 8'hC3, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0D, 8'h0A};
    int n;
    clear_obs();
    start_frame(8'h01, 16'h0203, 16'h0405);
    wait_pack(n);
    checks++; if (n !== FRAME) begin failures++; $display("FAIL b2b_len1 got=%0d exp=%0d", n, FRAME); end
    @(negedge sys_clk);
    checks++; if (tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
      failures++; $display("FAIL b2b_gap got busy=%b txd=%b exp 0/1", tx_busy, uart_txd); end
    send_en = 1'b1; dataA = 8'hC3; dataB = 16'h1234; dataC = 16'hABCD;
    @(negedge sys_clk);
    send_en = 1'b0;
    checks++; if (tx_busy !== 1'b1 || uart_txd !== 1'b0) begin
      failures++; $display("FAIL b2b_restart got busy=%b txd=%b exp 1/0", tx_busy, uart_txd); end
    wait_pack(n);
    checks++; if (n !== FRAME) begin failures++; $display("FAIL b2b_len2 got=%0d exp=%0d", n, FRAME); end
    @(negedge sys_clk);
    checks++; if (bd_cnt !== 16 || pd_cnt !== 2) begin
      failures++; $display("FAIL b2b_pulses got bd=%0d pd=%0d exp 16/2", bd_cnt, pd_cnt); end
    checks++; if (rx_q.size() !== 16) begin failures++; $display("FAIL b2b_nbytes got=%0d exp=16", rx_q.size()); end
    for (int k = 0; k < 16 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== {1'b1, exp[k]}) begin
        failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", k, rx_q[k], {1'b1, exp[k]}); end
    end
  endtask

  task automatic test_latch();
    logic [7:0] exp [8] = '{8'h55, 8'h5A, 8'hEF, 8'hBE, 8'hFE, 8'hCA, 8'h0D, 8'h0A};
    int n;
    clear_obs();
    start_frame(8'h5A, 16'hBEEF, 16'hCAFE);
    dataA = 8'h00; dataB = 16'hFFFF; dataC = 16'h0F0F;
    wait_pack(n);
    checks++; if (n !== FRAME) begin failures++; $display("FAIL latch_len got=%0d exp=%0d", n, FRAME); end
    @(negedge sys_clk);
    checks++; if (rx_q.size() !== 8) begin failures++; $display("FAIL latch_nbytes got=%0d exp=8", rx_q.size()); end
    for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== {1'b1, exp[k]}) begin
        failures++; $display("FAIL latch_byte%0d got=%h exp=%h", k, rx_q[k], {1'b1, exp[k]}); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    test_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
